// File: rtl/uart_tx_msg.sv
// UART transmit-side message sender: frames "ST-" + two uppercase hex digits of msg_data + "-#".
// Define UART_TX_CRLF_EN to append CR LF after '#', giving a 9-byte frame.
module uart_tx_msg #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] msg_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef UART_TX_CRLF_EN
    localparam int NUM_BYTES = 9;
`else
    localparam int NUM_BYTES = 7;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BYTE_LAST = 4'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic [7:0]       payload;
    logic [7:0]       cur_byte;
    logic             baud_last;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [7:0] p);
        logic [7:0] b;
        case (idx)
            4'd0:    b = 8'h53;
            4'd1:    b = 8'h54;
            4'd2:    b = 8'h2D;
            4'd3:    b = hex_ascii(p[7:4]);
            4'd4:    b = hex_ascii(p[3:0]);
            4'd5:    b = 8'h2D;
`ifdef UART_TX_CRLF_EN
            4'd7:    b = 8'h0D;
            4'd8:    b = 8'h0A;
`endif
            default: b = 8'h23;
        endcase
        return b;
    endfunction

    always_comb begin
        cur_byte  = frame_byte(byte_idx, payload);
        baud_last = (baud_cnt == CNT_LAST);
    end

    // tx is registered: each transition loads the level of the bit that starts next cycle.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            payload  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    if (send) begin
                        payload  <= msg_data;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START_BIT;
                    end
                end
                START_BIT: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= cur_byte[0];
                        state    <= DATA_BITS;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA_BITS: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP_BIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP_BIT: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (byte_idx == BYTE_LAST) begin
                            byte_idx <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Next byte's start bit follows the stop bit with no idle gap.
                            byte_idx <= byte_idx + 4'd1;
                            tx       <= 1'b0;
                            state    <= START_BIT;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_msg.sv
// Bench for uart_tx_msg: a line decoder reassembles UART bytes from tx and checks them
// against frames predicted from each accepted payload.
`timescale 1ns/1ps
module tb_uart_tx_msg;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int N        = CLK_FREQ / BAUD;
`ifdef UART_TX_CRLF_EN
    localparam int FRAME_BYTES = 9;
`else
    localparam int FRAME_BYTES = 7;
`endif
    localparam int FRAME_CYCLES = FRAME_BYTES * 10 * N;

    logic       clk_50M  = 1'b0;
    logic       reset    = 1'b1;
    logic       send     = 1'b0;
    logic [7:0] msg_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int frames_expected = 0;
    int frames_seen     = 0;
    int frame_start     = 0;
    int bytes_in_frame  = 0;
    int last_done_cyc   = -100;
    bit expect_tight_gap = 1'b0;

    uart_tx_msg #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .send    (send),
        .msg_data(msg_data),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    initial begin : watchdog
        #(40000 * 10);
        $display("FAIL watchdog: simulation exceeded 40000 cycles, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] hex_char(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + (n - 10));
    endfunction

    task automatic push_frame(input logic [7:0] p);
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h2D);
        exp_q.push_back(hex_char(int'(p) / 16));
        exp_q.push_back(hex_char(int'(p) % 16));
        exp_q.push_back(8'h2D);
        exp_q.push_back(8'h23);
`ifdef UART_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
        frames_expected++;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 2 * FRAME_CYCLES) begin
            @(negedge clk_50M);
            n++;
        end
        if (n >= 2 * FRAME_CYCLES) check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < FRAME_CYCLES + 50) begin
            @(negedge clk_50M);
            n++;
        end
        checks++;
        if (n >= FRAME_CYCLES + 50) begin
            errors++;
            $display("FAIL wait_done: no done pulse within %0d cycles, required one", FRAME_CYCLES + 50);
        end
    endtask

    task automatic issue_send(input logic [7:0] p);
        wait_idle();
        send     = 1'b1;
        msg_data = p;
        push_frame(p);
        @(negedge clk_50M);
        send     = 1'b0;
        msg_data = 8'($urandom_range(0, 255));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : line_monitor
        logic [9:0] bits;
        logic [7:0] exp_b;
        bit aborted, steady, stray_done, busy_ok;
        forever begin
            @(negedge clk_50M);
            if (reset) begin
                bytes_in_frame = 0;
                continue;
            end
            if (done === 1'b1) begin
                check("done_byte_count", 32'(bytes_in_frame), 32'(FRAME_BYTES));
                check("frame_duration", 32'(cyc - frame_start), 32'(FRAME_CYCLES));
                check("busy_low_at_done", 32'(busy), 32'd0);
                frames_seen++;
                bytes_in_frame = 0;
                last_done_cyc  = cyc;
            end
            if (tx === 1'b0) begin
                if (bytes_in_frame == 0) begin
                    frame_start = cyc;
                    if (expect_tight_gap) begin
                        check("idle_gap", 32'(cyc - last_done_cyc), 32'd1);
                        expect_tight_gap = 1'b0;
                    end
                end
                aborted = 0; steady = 1; stray_done = 0; busy_ok = 1;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int j = 0; j < N; j++) begin
                        if (b != 0 || j != 0) @(negedge clk_50M);
                        if (reset) begin
                            aborted = 1;
                            break;
                        end
                        if (done !== 1'b0) stray_done = 1;
                        if (busy !== 1'b1) busy_ok = 0;
                        if (j == 0) bits[b] = tx;
                        else if (tx !== bits[b]) steady = 0;
                    end
                end
                if (aborted) begin
                    bytes_in_frame = 0;
                end else begin
                    check("bit_timing", 32'(steady), 32'd1);
                    check("done_in_frame", 32'(stray_done), 32'd0);
                    check("busy_in_frame", 32'(busy_ok), 32'd1);
                    check("start_bit", 32'(bits[0]), 32'd0);
                    check("stop_bit", 32'(bits[9]), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h required no byte", bits[8:1]);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("frame_byte", 32'(bits[8:1]), 32'(exp_b));
                    end
                    bytes_in_frame++;
                end
            end else begin
                check("idle_busy", 32'(busy), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int gap;
        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_50M);
            check("reset_tx", 32'(tx), 32'd1);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_done", 32'(done), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50M);
            check("quiet_tx", 32'(tx), 32'd1);
            check("quiet_done", 32'(done), 32'd0);
        end

        // Basic frame and hex boundaries.
        issue_send(8'h3A); wait_done();
        issue_send(8'h00); wait_done();
        issue_send(8'hFF); wait_done();
        issue_send(8'h9A); wait_done();

        // send while busy is ignored; payload is held.
        issue_send(8'hC4);
        repeat (200) @(negedge clk_50M);
        send = 1'b1; msg_data = 8'h55;
        @(negedge clk_50M);
        send = 1'b0;
        wait_done();
        repeat (5) @(negedge clk_50M);

        // Reset during data bits of byte index 3.
        issue_send(8'($urandom_range(0, 255)));
        repeat (33 * N) @(negedge clk_50M);
        reset = 1'b1;
        @(negedge clk_50M);
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        @(negedge clk_50M);
        reset = 1'b0;
        exp_q.delete();
        frames_expected--;
        repeat (20) @(negedge clk_50M);
        issue_send(8'($urandom_range(0, 255))); wait_done();

        // Randomised payloads with random idle gaps.
        for (int k = 0; k < 4; k++) begin
            gap = int'($urandom_range(0, 5));
            repeat (gap) @(negedge clk_50M);
            issue_send(8'($urandom_range(0, 255)));
            wait_done();
        end

        // Back-to-back: send held high yields frames one idle cycle apart.
        wait_idle();
        send = 1'b1; msg_data = 8'h12;
        push_frame(8'h12);
        push_frame(8'h12);
        @(negedge clk_50M);
        wait_done();
        expect_tight_gap = 1'b1;
        @(negedge clk_50M);
        wait_done();
        send = 1'b0;
        repeat (30) @(negedge clk_50M);

        check("frames_completed", 32'(frames_seen), 32'(frames_expected));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_tx", 32'(tx), 32'd1);
        check("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_msg.md
Name: uart_tx_msg

Overview:
- Transmit-side message sender for the team's UART link; the counterpart of the receive-side command detector.
- On a send request it serialises a fixed 7-byte ASCII frame, "ST-" + two uppercase hex digits of an 8-bit payload + "-#", onto the UART tx line.
- Contains its own baud timing and shift logic. Sits between control logic and the tx pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 434 at defaults), clock cycles per UART bit.

Ports:
- clk_50M  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- send  input  1  request to transmit one frame; sampled only when busy=0.
- msg_data  input  8  payload byte, encoded as two ASCII hex digits; latched when send is accepted.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high from the cycle after acceptance until the frame completes.
- done  output  1  single-cycle pulse at frame completion.

Behaviour:
- Reset (synchronous, any state, including mid-frame): next edge forces tx=1, busy=0, done=0, FSM=IDLE, and clears the byte index, bit index and baud counter. No partial byte is completed.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit holds tx for exactly CLKS_PER_BIT cycles.
- Frame byte sequence:
  - 0x53 'S', 0x54 'T', 0x2D '-'.
  - HEX(msg_data[7:4]), HEX(msg_data[3:0]).
  - 0x2D '-', 0x23 '#'.
  - HEX(n): n in 0..9 gives 0x30+n; n in 10..15 gives 0x41+(n-10) (uppercase).
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
  - IDLE: tx=1, busy=0. If send=1, latch msg_data, set byte index 0 and go to START_BIT. busy=1 and tx=0 from the next cycle, so latency is 1 cycle from send to start-bit edge.
  - START_BIT: after CLKS_PER_BIT cycles, go to DATA_BITS with bit index 0.
  - DATA_BITS: drive the current byte bit[idx]. After CLKS_PER_BIT cycles, increment idx. After bit 7, go to STOP_BIT.
  - STOP_BIT: after CLKS_PER_BIT cycles:
    - if more bytes remain, increment byte index and go directly to START_BIT (no idle gap between bytes);
    - otherwise go to IDLE, assert done for one cycle, and drop busy in that same cycle.
- Frame duration: exactly 7*10*CLKS_PER_BIT cycles from the first start-bit cycle to the done cycle.
- send while busy=1 is ignored, not queued.
- Changes on msg_data after acceptance do not affect the frame in flight.
- send=1 in the done cycle (busy=0) is accepted. The next frame's start bit begins the following cycle, giving back-to-back frames with one idle-high cycle.
- send held high continuously: a new frame starts after each completion.
- Baud counter width is clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.

Optional Feature:
- Macro UART_TX_CRLF_EN.
- Defined: frame is 9 bytes, with 0x0D (CR) and 0x0A (LF) appended after '#'. Frame duration is 9*10*CLKS_PER_BIT cycles and done is asserted after the LF stop bit.
- Undefined: 7-byte frame as above; no CR/LF logic present.

Test Plan:
- Reset values: assert reset for 3 cycles -> tx=1, busy=0, done=0 throughout and after release; no activity without send.
- Basic frame: CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10), msg_data=0x3A, 1-cycle send.
  - Decoded bytes: 0x53 0x54 0x2D 0x33 0x41 0x2D 0x23.
  - Each bit lasts 10 cycles; done pulses once, 700 cycles after the first start-bit cycle.
- Hex boundaries: msg_data=0x00 -> digits 0x30 0x30; msg_data=0xFF -> digits 0x46 0x46; msg_data=0x9A -> digits 0x39 0x41.
- Busy handling: pulse send again mid-frame and change msg_data to 0x55 -> ignored; the frame still encodes the original payload; only one done pulse.
- Reset mid-frame: assert reset during DATA_BITS of byte 3 -> tx=1 and busy=0 on the next edge, no done pulse; a subsequent send produces a complete, correct frame.
- Back-to-back: send held high with msg_data=0x12 -> two frames separated by exactly one idle-high cycle, with done pulsing at each completion. With UART_TX_CRLF_EN defined, each frame ends with 0x0D 0x0A and lasts 900 cycles.
